// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: token-ring transmit scheduler. Merges the forward (RX)
// path and local injection into one registered transmit stage, granting local
// traffic only while this node holds the token (at most MAX_BURST words per
// hold). Optional statistics counters are built when TXARB_STATS_EN is defined.
module tx_link_scheduler #(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned INIT_TOKEN = 0
) (
  input  logic        Clk_R,
  input  logic        Rst,
  input  logic        Fwd_Valid,
  input  logic [54:0] Fwd_Data,
  output logic        Fwd_Ready,
  input  logic        Local_Valid,
  input  logic [54:0] Local_Data,
  output logic        Local_Ready,
  output logic        TX_Data_Valid,
  output logic [54:0] TX_Data,
  input  logic        TX_Data_Ready
`ifdef TXARB_STATS_EN
  ,
  output logic [15:0] Local_Sent_Cnt,
  output logic [15:0] Token_Pass_Cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_e;

  localparam logic [54:0] TOKEN_RST  = 55'h40_0000_0000_0000;
  localparam logic [54:0] LOCAL_MASK = {1'b0, {54{1'b1}}};
  localparam logic [3:0]  BURST_MAX  = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic        tx_valid_q, tx_valid_d;
  logic [54:0] tx_data_q, tx_data_d;
  logic [54:0] token_q, token_d;
  logic [3:0]  burst_q, burst_d;
  logic        last_local_q, last_local_d;

  logic        out_free;
  logic        fwd_is_token;
  logic        fwd_rdy;
  logic        loc_rdy;
  logic        tok_emit;
  logic [3:0]  burst_inc;

  assign out_free     = !tx_valid_q || TX_Data_Ready;
  assign fwd_is_token = Fwd_Data[54];
  assign burst_inc    = burst_q + 4'd1;

  // Next-state, arbitration and output-register load
  always_comb begin
    state_d      = state_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    token_d      = token_q;
    burst_d      = burst_q;
    last_local_d = last_local_q;
    fwd_rdy      = 1'b0;
    loc_rdy      = 1'b0;
    tok_emit     = 1'b0;

    // A free register with nothing loaded this cycle goes empty.
    if (out_free) tx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Fwd_Valid && fwd_is_token) begin
          // Token capture does not need the output register.
          fwd_rdy = 1'b1;
          token_d = Fwd_Data;
          state_d = Local_Valid ? HOLD : RELEASE;
        end else if (Fwd_Valid && out_free) begin
          fwd_rdy    = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = Fwd_Data;
        end
      end

      HOLD: begin
        if (out_free) begin
          if (Local_Valid && (!(Fwd_Valid && !fwd_is_token) || !last_local_q)) begin
            loc_rdy      = 1'b1;
            tx_valid_d   = 1'b1;
            tx_data_d    = Local_Data & LOCAL_MASK;
            last_local_d = 1'b1;
            burst_d      = burst_inc;
            if (burst_inc == BURST_MAX) state_d = RELEASE;
          end else if (Fwd_Valid && !fwd_is_token) begin
            fwd_rdy      = 1'b1;
            tx_valid_d   = 1'b1;
            tx_data_d    = Fwd_Data;
            last_local_d = 1'b0;
          end
          if (!Local_Valid) state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (out_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = token_q;
          burst_d    = '0;
          tok_emit   = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Fwd_Ready     = fwd_rdy && !Rst;
  assign Local_Ready   = loc_rdy && !Rst;
  assign TX_Data_Valid = tx_valid_q;
  assign TX_Data       = tx_data_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state_q      <= (INIT_TOKEN != 0) ? HOLD : IDLE;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      token_q      <= (INIT_TOKEN != 0) ? TOKEN_RST : '0;
      burst_q      <= '0;
      last_local_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      token_q      <= token_d;
      burst_q      <= burst_d;
      last_local_q <= last_local_d;
    end
  end

`ifdef TXARB_STATS_EN
  logic [15:0] local_cnt_q, local_cnt_d;
  logic [15:0] token_cnt_q, token_cnt_d;

  // Saturating traffic counters
  always_comb begin
    local_cnt_d = local_cnt_q;
    token_cnt_d = token_cnt_q;
    if (loc_rdy && Local_Valid && (local_cnt_q != '1)) local_cnt_d = local_cnt_q + 16'd1;
    if (tok_emit && (token_cnt_q != '1)) token_cnt_d = token_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      local_cnt_q <= '0;
      token_cnt_q <= '0;
    end else begin
      local_cnt_q <= local_cnt_d;
      token_cnt_q <= token_cnt_d;
    end
  end

  assign Local_Sent_Cnt = local_cnt_q;
  assign Token_Pass_Cnt = token_cnt_q;
`endif

endmodule
